// File: rtl/rv32_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_inst_encoder
//  Description : Combinational RV32I instruction encoder feeding a 2-entry
//                output FIFO with valid/ready handshakes on both sides and a
//                16-bit accepted-request counter.
//                Optional macro RV32_ENC_IMM_CHECK_EN enables immediate range
//                checking (out-of-range requests are rejected as a NOP).
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_inst_encoder (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [4:0]  i_op,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [31:0] i_imm,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_inst,
   output logic        o_invalid,
   output logic [15:0] o_count
);

   localparam logic [6:0]  OPC_R      = 7'b0110011;
   localparam logic [6:0]  OPC_I      = 7'b0010011;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;
   localparam logic [6:0]  OPC_LUI    = 7'b0110111;
   localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
   localparam logic [31:0] NOP_INST   = 32'h0000_0013;

   // Immediate range flags; without the check every immediate is accepted
   // and simply truncated to the format's bits.
   logic i_fmt_ok, b_fmt_ok, j_fmt_ok, u_fmt_ok;
`ifdef RV32_ENC_IMM_CHECK_EN
   assign i_fmt_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);
   assign b_fmt_ok = ((&i_imm[31:12]) | ~(|i_imm[31:12])) & ~i_imm[0];
   assign j_fmt_ok = ((&i_imm[31:20]) | ~(|i_imm[31:20])) & ~i_imm[0];
   assign u_fmt_ok = ~(|i_imm[11:0]);
`else
   assign i_fmt_ok = 1'b1;
   assign b_fmt_ok = 1'b1;
   assign j_fmt_ok = 1'b1;
   assign u_fmt_ok = 1'b1;
`endif

   logic [31:0] enc_inst;
   logic        enc_bad;
   logic        fmt_ok;
   logic        op_ok;

   // Encode the request fields into an instruction word (or reject it)
   always_comb begin
      enc_inst = '0;
      fmt_ok   = 1'b1;
      op_ok    = 1'b1;
      case (i_op)
         5'd0:  enc_inst = {7'b0000000, i_rs2, i_rs1, 3'b000, i_rd, OPC_R};
         5'd1:  enc_inst = {7'b0100000, i_rs2, i_rs1, 3'b000, i_rd, OPC_R};
         5'd2:  enc_inst = {7'b0000000, i_rs2, i_rs1, 3'b010, i_rd, OPC_R};
         5'd3:  enc_inst = {7'b0000000, i_rs2, i_rs1, 3'b011, i_rd, OPC_R};
         5'd4:  begin enc_inst = {i_imm[11:0], i_rs1, 3'b000, i_rd, OPC_I};    fmt_ok = i_fmt_ok; end
         5'd5:  begin enc_inst = {i_imm[11:0], i_rs1, 3'b010, i_rd, OPC_I};    fmt_ok = i_fmt_ok; end
         5'd6:  begin enc_inst = {i_imm[11:0], i_rs1, 3'b011, i_rd, OPC_I};    fmt_ok = i_fmt_ok; end
         5'd7:  begin enc_inst = {i_imm[11:0], i_rs1, 3'b010, i_rd, OPC_LOAD}; fmt_ok = i_fmt_ok; end
         5'd8:  begin
            enc_inst = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], OPC_STORE};
            fmt_ok   = i_fmt_ok;
         end
         5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14: begin
            // funct3 for BEQ..BGEU: 000,001,100,101,110,111
            enc_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, 3'b000,
                        i_imm[4:1], i_imm[11], OPC_BRANCH};
            case (i_op)
               5'd10:   enc_inst[14:12] = 3'b001;
               5'd11:   enc_inst[14:12] = 3'b100;
               5'd12:   enc_inst[14:12] = 3'b101;
               5'd13:   enc_inst[14:12] = 3'b110;
               5'd14:   enc_inst[14:12] = 3'b111;
               default: enc_inst[14:12] = 3'b000;
            endcase
            fmt_ok = b_fmt_ok;
         end
         5'd15: begin
            enc_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
            fmt_ok   = j_fmt_ok;
         end
         5'd16: begin enc_inst = {i_imm[11:0], i_rs1, 3'b000, i_rd, OPC_JALR}; fmt_ok = i_fmt_ok; end
         5'd17: begin enc_inst = {i_imm[31:12], i_rd, OPC_LUI};   fmt_ok = u_fmt_ok; end
         5'd18: begin enc_inst = {i_imm[31:12], i_rd, OPC_AUIPC}; fmt_ok = u_fmt_ok; end
         default: op_ok = 1'b0;
      endcase
      enc_bad = ~op_ok | ~fmt_ok;
      if (enc_bad) begin
         enc_inst = NOP_INST;
      end
   end

   // FIFO state: two entries of {inst, invalid}
   logic [32:0] mem_q [2];
   logic [32:0] mem_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  occ_q, occ_d;
   logic [15:0] cnt_q, cnt_d;
   logic        ready_q, ready_d;
   logic        push, pop;

   // ready is a flop so it reads 0 through reset and rises one edge later
   assign o_ready   = ready_q;
   assign o_valid   = (occ_q != 2'd0);
   assign o_inst    = o_valid ? mem_q[rd_ptr_q][32:1] : 32'h0;
   assign o_invalid = o_valid ? mem_q[rd_ptr_q][0]    : 1'b0;
   assign o_count   = cnt_q;
   assign push      = i_valid & ready_q;
   assign pop       = o_valid & i_ready;

   // Next-state for FIFO pointers, occupancy, counter and ready flag
   always_comb begin
      mem_d[0] = mem_q[0];
      mem_d[1] = mem_q[1];
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = {enc_inst, enc_bad};
         wr_ptr_d        = ~wr_ptr_q;
         cnt_d           = cnt_q + 16'd1;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
      ready_d = (occ_d < 2'd2);
   end

   // State registers with synchronous active-low reset; storage is not reset
   always_ff @(posedge i_clk) begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      if (!i_rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         cnt_q    <= 16'd0;
         ready_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rv32_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_inst_encoder
//  Description : Self-checking bench for rv32_inst_encoder (scoreboard of
//                expected {inst, invalid} entries plus directed checks).
//                Honours RV32_ENC_IMM_CHECK_EN for expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_inst_encoder;

   logic        i_clk = 1'b0;
   logic        i_rst_n, i_valid, i_ready;
   logic [4:0]  i_op, i_rd, i_rs1, i_rs2;
   logic [31:0] i_imm;
   logic        o_ready, o_valid, o_invalid;
   logic [31:0] o_inst;
   logic [15:0] o_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [32:0] sb [$];
   logic [15:0] exp_cnt = 16'd0;
   logic        hold_v  = 1'b0;
   logic [32:0] hold_d  = '0;

   rv32_inst_encoder dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_op     (i_op),
      .i_rd     (i_rd),
      .i_rs1    (i_rs1),
      .i_rs2    (i_rs2),
      .i_imm    (i_imm),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_inst   (o_inst),
      .o_invalid(o_invalid),
      .o_count  (o_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference encoder built from shifted fields
   function automatic logic [32:0] model(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
      logic [31:0] w, f3;
      logic        ok;
      int          s;
      logic [31:0] rds, r1s, r2s;
      s   = $signed(imm);
      rds = 32'(rd) << 7;
      r1s = 32'(rs1) << 15;
      r2s = 32'(rs2) << 20;
      ok  = 1'b1;
      w   = 32'h0;
      f3  = 32'h0;
      case (op)
         5'd0, 5'd1, 5'd2, 5'd3: begin
            f3 = (op == 5'd2) ? 32'd2 : (op == 5'd3) ? 32'd3 : 32'd0;
            w  = ((op == 5'd1) ? 32'h4000_0000 : 32'h0) | r2s | r1s | (f3 << 12) | rds | 32'h33;
         end
         5'd4, 5'd5, 5'd6, 5'd7, 5'd16: begin
            f3 = (op == 5'd5 || op == 5'd7) ? 32'd2 : (op == 5'd6) ? 32'd3 : 32'd0;
            w  = (imm << 20) | r1s | (f3 << 12) | rds |
                 ((op == 5'd7) ? 32'h03 : (op == 5'd16) ? 32'h67 : 32'h13);
            ok = (s >= -2048) && (s <= 2047);
         end
         5'd8: begin
            w  = (((imm >> 5) & 32'h7F) << 25) | r2s | r1s | (32'd2 << 12) |
                 ((imm & 32'h1F) << 7) | 32'h23;
            ok = (s >= -2048) && (s <= 2047);
         end
         5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14: begin
            case (op)
               5'd9:    f3 = 32'd0;
               5'd10:   f3 = 32'd1;
               5'd11:   f3 = 32'd4;
               5'd12:   f3 = 32'd5;
               5'd13:   f3 = 32'd6;
               default: f3 = 32'd7;
            endcase
            w  = (32'(imm[12]) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2s | r1s |
                 (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (32'(imm[11]) << 7) | 32'h63;
            ok = (s >= -4096) && (s <= 4095) && !imm[0];
         end
         5'd15: begin
            w  = (32'(imm[20]) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                 (32'(imm[11]) << 20) | (imm & 32'h000F_F000) | rds | 32'h6F;
            ok = (s >= -1048576) && (s <= 1048575) && !imm[0];
         end
         5'd17, 5'd18: begin
            w  = (imm & 32'hFFFF_F000) | rds | ((op == 5'd17) ? 32'h37 : 32'h17);
            ok = ((imm & 32'hFFF) == 32'h0);
         end
         default: return {32'h0000_0013, 1'b1};
      endcase
`ifndef RV32_ENC_IMM_CHECK_EN
      ok = 1'b1;
`endif
      return ok ? {w, 1'b0} : {32'h0000_0013, 1'b1};
   endfunction

   // Scoreboard monitor: samples handshakes mid-cycle, away from the active edge
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         sb.delete();
         exp_cnt = 16'd0;
         hold_v  = 1'b0;
      end else begin
         check("count", {17'h0, o_count}, {17'h0, exp_cnt});
         if (o_valid) begin
            if (hold_v) check("stable", {o_inst, o_invalid}, hold_d);
            if (i_ready) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $error("FAIL sb_underflow: observed %h expected none", {o_inst, o_invalid});
               end else begin
                  check("pop", {o_inst, o_invalid}, sb.pop_front());
               end
            end
            hold_v = !i_ready;
            hold_d = {o_inst, o_invalid};
         end else begin
            check("idle_zero", {o_inst, o_invalid}, 33'h0);
            hold_v = 1'b0;
         end
         if (i_valid && o_ready) begin
            sb.push_back(model(i_op, i_rd, i_rs1, i_rs2, i_imm));
            exp_cnt = exp_cnt + 16'd1;
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
      i_op = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_valid = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
      i_op = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_imm = '0;
      tick(); tick();
      check("rst_valid", {32'h0, o_valid}, 33'h0);
      check("rst_ready", {32'h0, o_ready}, 33'h0);
      check("rst_count", {17'h0, o_count}, 33'h0);
      check("rst_inst",  {o_inst, o_invalid}, 33'h0);
      i_rst_n = 1'b1;
      tick();
      check("ready_after_rst", {32'h0, o_ready}, 33'h1);

      // Directed known-answer encodings, one per cycle, consumer always ready
      i_ready = 1'b1;
      drive(5'd0, 5'd3, 5'd1, 5'd2, 32'h0);            tick();
      check("add", {o_valid, o_inst, o_invalid}, {1'b1, 32'h002081B3, 1'b0});
      drive(5'd1, 5'd3, 5'd1, 5'd2, 32'h0);            tick();
      check("sub", {o_inst, o_invalid}, {32'h402081B3, 1'b0});
      drive(5'd4, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);    tick();
      check("addi_m1", {o_inst, o_invalid}, {32'hFFF00093, 1'b0});
      drive(5'd9, 5'd0, 5'd1, 5'd2, 32'd8);            tick();
      check("beq", {o_inst, o_invalid}, {32'h00208463, 1'b0});
      drive(5'd4, 5'd1, 5'd0, 5'd0, 32'd2048);         tick();
`ifdef RV32_ENC_IMM_CHECK_EN
      check("addi_2048", {o_inst, o_invalid}, {32'h00000013, 1'b1});
`else
      check("addi_2048", {o_inst, o_invalid}, {32'h80000093, 1'b0});
`endif
      drive(5'd25, 5'd7, 5'd7, 5'd7, 32'h1234_5678);   tick();
      check("unsupported", {o_inst, o_invalid}, {32'h00000013, 1'b1});
      drive(5'd17, 5'd5, 5'd0, 5'd0, 32'hABCDE000);    tick();
      check("lui", {o_inst, o_invalid}, {32'hABCDE2B7, 1'b0});
      i_valid = 1'b0;
      tick();
      check("drained", {32'h0, o_valid}, 33'h0);

      // Random traffic with random backpressure
      for (int k = 0; k < 300; k++) begin
         i_valid = 1'($urandom);
         i_ready = 1'($urandom);
         i_op    = 5'($urandom_range(0, 31));
         i_rd    = 5'($urandom);
         i_rs1   = 5'($urandom);
         i_rs2   = 5'($urandom);
         case ($urandom_range(0, 2))
            0:       i_imm = 32'($urandom_range(0, 80)) - 32'd40;
            1:       i_imm = $urandom & 32'hFFFF_F000;
            default: i_imm = $urandom;
         endcase
         tick();
      end
      i_valid = 1'b0; i_ready = 1'b1;
      tick(); tick(); tick();
      check("rand_drained", {32'h0, o_valid}, 33'h0);
      check("sb_empty", 33'(sb.size()), 33'h0);

      // Backpressure: three back-to-back requests, consumer stalled
      i_rst_n = 1'b0; tick();
      i_rst_n = 1'b1; tick();
      i_ready = 1'b0;
      drive(5'd0, 5'd3, 5'd1, 5'd2, 32'h0);            tick();
      drive(5'd1, 5'd3, 5'd1, 5'd2, 32'h0);            tick();
      drive(5'd9, 5'd0, 5'd1, 5'd2, 32'd8);            tick();
      check("bp_ready_low", {32'h0, o_ready}, 33'h0);
      check("bp_count2", {17'h0, o_count}, 33'd2);
      check("bp_head", {o_inst, o_invalid}, {32'h002081B3, 1'b0});
      i_ready = 1'b1;                                  tick();
      check("bp_second", {o_inst, o_invalid}, {32'h402081B3, 1'b0});
      tick();
      i_valid = 1'b0;
      check("bp_third", {o_inst, o_invalid}, {32'h00208463, 1'b0});
      tick();
      check("bp_empty", {32'h0, o_valid}, 33'h0);
      check("bp_count3", {17'h0, o_count}, 33'd3);

      // Reset with two entries queued
      i_ready = 1'b0;
      drive(5'd2, 5'd4, 5'd5, 5'd6, 32'h0);            tick();
      drive(5'd3, 5'd4, 5'd5, 5'd6, 32'h0);            tick();
      i_valid = 1'b0;
      check("mr_full", {31'h0, o_valid, o_ready}, 33'b10);
      i_rst_n = 1'b0;                                  tick();
      check("mr_valid", {32'h0, o_valid}, 33'h0);
      check("mr_count", {17'h0, o_count}, 33'h0);
      i_rst_n = 1'b1;                                  tick();
      check("mr_ready", {32'h0, o_ready}, 33'h1);
      check("mr_valid2", {32'h0, o_valid}, 33'h0);
      check("mr_count2", {17'h0, o_count}, 33'h0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
